// File: rtl/elevator_timer_ctrl.sv
// Shared timing controller for the elevator: one prescaler producing a
// single-cycle tick enable, and one tick-down timer shared round-robin
// between the door FSM and the motor/travel FSM.
module elevator_timer_ctrl #(
  parameter int PRESCALE = 50_000_000,
  parameter int TICK_W   = 4
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              req_door,
  input  logic [TICK_W-1:0] dur_door,
  input  logic              req_move,
  input  logic [TICK_W-1:0] dur_move,
  input  logic              cancel,
  output logic              grant_door,
  output logic              grant_move,
  output logic              busy,
  output logic              done_door,
  output logic              done_move,
  output logic              tick_out
);

  localparam int                 PRESC_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESCALE - 1);
  localparam logic [TICK_W-1:0]  ONE_TICK  = TICK_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_DOOR = 2'd1,
    RUN_MOVE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [PRESC_W-1:0]  presc;
  logic [PRESC_W-1:0]  presc_next;
  logic [TICK_W-1:0]   remain;
  logic [TICK_W-1:0]   remain_next;
  logic                last_move;
  logic                last_move_next;
  logic                done_door_q;
  logic                done_door_next;
  logic                done_move_q;
  logic                done_move_next;

  logic                tick;
  logic                pick_door;
  logic                pick_move;
  logic [TICK_W-1:0]   dur_door_eff;
  logic [TICK_W-1:0]   dur_move_eff;

  // Tick decode from the prescaler register (0 in reset since presc is 0).
  assign tick = (presc == PRESC_MAX);

  // Round-robin choice: on a tie the requester not served last wins.
  always_comb begin
    pick_door = req_door & (~req_move | last_move);
    pick_move = req_move & (~req_door | ~last_move);
  end

  // A zero-length request is served as a one-tick interval.
  always_comb begin
    dur_door_eff = (dur_door == '0) ? ONE_TICK : dur_door;
    dur_move_eff = (dur_move == '0) ? ONE_TICK : dur_move;
  end

  // Next-state, timer and done-pulse logic for the shared timer FSM.
  always_comb begin
    state_next     = state;
    remain_next    = remain;
    last_move_next = last_move;
    done_door_next = 1'b0;
    done_move_next = 1'b0;
    presc_next     = tick ? '0 : presc + PRESC_W'(1);

    case (state)
      IDLE: begin
        // cancel has no meaning here; arbitration proceeds regardless
        if (pick_door) begin
          state_next     = RUN_DOOR;
          remain_next    = dur_door_eff;
          last_move_next = 1'b0;
          presc_next     = '0;
        end else if (pick_move) begin
          state_next     = RUN_MOVE;
          remain_next    = dur_move_eff;
          last_move_next = 1'b1;
          presc_next     = '0;
        end
      end

      RUN_DOOR: begin
        // cancel takes priority over an expiry tick in the same cycle
        if (cancel) begin
          state_next = IDLE;
        end else if (tick) begin
          if (remain <= ONE_TICK) begin
            state_next     = IDLE;
            done_door_next = 1'b1;
          end else begin
            remain_next = remain - ONE_TICK;
          end
        end
      end

      RUN_MOVE: begin
        if (cancel) begin
          state_next = IDLE;
        end else if (tick) begin
          if (remain <= ONE_TICK) begin
            state_next     = IDLE;
            done_move_next = 1'b1;
          end else begin
            remain_next = remain - ONE_TICK;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register; reset aborts any interval without a done pulse.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      presc       <= '0;
      remain      <= '0;
      last_move   <= 1'b1;
      done_door_q <= 1'b0;
      done_move_q <= 1'b0;
    end else begin
      state       <= state_next;
      presc       <= presc_next;
      remain      <= remain_next;
      last_move   <= last_move_next;
      done_door_q <= done_door_next;
      done_move_q <= done_move_next;
    end
  end

  // Outputs are decoded straight from registers, so reset clears them at once.
  always_comb begin
    grant_door = (state == RUN_DOOR);
    grant_move = (state == RUN_MOVE);
    busy       = grant_door | grant_move;
    done_door  = done_door_q;
    done_move  = done_move_q;
    tick_out   = tick;
  end

endmodule

// File: tb/tb_elevator_timer_ctrl.sv
// Bench for elevator_timer_ctrl: directed scenarios push expected grant
// rise/fall and done events (with the clock-edge index) into a queue; an
// independent monitor pops and compares whenever the DUT shows one.
module tb_elevator_timer_ctrl;

  localparam int PRESCALE = 4;
  localparam int TICK_W   = 4;

  localparam int K_GD = 0;
  localparam int K_GM = 1;
  localparam int K_FD = 2;
  localparam int K_FM = 3;
  localparam int K_DD = 4;
  localparam int K_DM = 5;

  logic              clk_in   = 1'b0;
  logic              rst_n    = 1'b0;
  logic              req_door = 1'b0;
  logic              req_move = 1'b0;
  logic              cancel   = 1'b0;
  logic [TICK_W-1:0] dur_door = '0;
  logic [TICK_W-1:0] dur_move = '0;
  logic              grant_door;
  logic              grant_move;
  logic              busy;
  logic              done_door;
  logic              done_move;
  logic              tick_out;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;

  elevator_timer_ctrl #(
    .PRESCALE(PRESCALE),
    .TICK_W  (TICK_W)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .req_door  (req_door),
    .dur_door  (dur_door),
    .req_move  (req_move),
    .dur_move  (dur_move),
    .cancel    (cancel),
    .grant_door(grant_door),
    .grant_move(grant_move),
    .busy      (busy),
    .done_door (done_door),
    .done_move (done_move),
    .tick_out  (tick_out)
  );

  always #5 clk_in = ~clk_in;

  // Edge counter: value equals the index of the latest rising edge.
  initial begin
    forever begin
      @(posedge clk_in);
      cyc++;
    end
  end

  function automatic string kname(input int k);
    case (k)
      K_GD:    return "grant_door_rise";
      K_GM:    return "grant_move_rise";
      K_FD:    return "grant_door_fall";
      K_FM:    return "grant_move_fall";
      K_DD:    return "done_door";
      default: return "done_move";
    endcase
  endfunction

  task automatic push(input int kind, input int c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, got, want);
    end
  endtask

  task automatic observe(input int kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: got %s@%0d, expected none", kname(kind), cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc) begin
        failures++;
        $display("FAIL event: got %s@%0d, expected %s@%0d",
                 kname(kind), cyc, kname(e.kind), e.cyc);
      end
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    logic pgd;
    logic pgm;
    pgd = 1'b0;
    pgm = 1'b0;
    forever begin
      @(negedge clk_in);
      chk("busy_eq_grants", 32'(busy), 32'(grant_door | grant_move));
      if (grant_door && !pgd) observe(K_GD);
      if (grant_move && !pgm) observe(K_GM);
      if (!grant_door && pgd) observe(K_FD);
      if (!grant_move && pgm) observe(K_FM);
      if (done_door) observe(K_DD);
      if (done_move) observe(K_DM);
      pgd = grant_door;
      pgm = grant_move;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    int g;
    int r;

    // Reset values and free-running tick
    rst_n = 1'b0;
    step(5);
    chk("reset_outputs", 32'({grant_door, grant_move, busy, done_door, done_move, tick_out}), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("release_outputs", 32'({grant_door, grant_move, busy, done_door, done_move, tick_out}), 32'd0);
    for (int i = 1; i <= 9; i++) begin
      step(1);
      chk("tick_free", 32'(tick_out), 32'((i % 4) == 3));
    end

    // Single door interval, dur 3 -> 12 cycles; tick restarts at grant
    req_door = 1'b1;
    dur_door = 4'd3;
    g = cyc + 1;
    push(K_GD, g);
    push(K_FD, g + 12);
    push(K_DD, g + 12);
    for (int i = 0; i <= 13; i++) begin
      step(1);
      if (i == 0) req_door = 1'b0;
      chk("tick_interval", 32'(tick_out), 32'((i % 4) == 3));
    end

    // Tie from reset: door, move, door with one idle cycle between
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    req_door = 1'b1;
    req_move = 1'b1;
    dur_door = 4'd1;
    dur_move = 4'd1;
    g = cyc + 1;
    push(K_GD, g);
    push(K_FD, g + 4);
    push(K_DD, g + 4);
    push(K_GM, g + 5);
    push(K_FM, g + 9);
    push(K_DM, g + 9);
    push(K_GD, g + 10);
    push(K_FD, g + 14);
    push(K_DD, g + 14);
    step(11);
    req_door = 1'b0;
    req_move = 1'b0;
    step(6);

    // Zero duration behaves as one tick; mid-run dur change ignored
    req_move = 1'b1;
    dur_move = 4'd0;
    g = cyc + 1;
    push(K_GM, g);
    push(K_FM, g + 4);
    push(K_DM, g + 4);
    step(1);
    dur_move = 4'd9;
    step(2);
    req_move = 1'b0;
    step(4);

    // Cancel 2 cycles after grant; cancelled door then loses the tie,
    // and cancel held high in IDLE does not block arbitration
    req_door = 1'b1;
    dur_door = 4'd5;
    g = cyc + 1;
    push(K_GD, g);
    push(K_FD, g + 2);
    step(1);
    req_door = 1'b0;
    step(1);
    cancel = 1'b1;
    step(1);
    req_door = 1'b1;
    req_move = 1'b1;
    dur_door = 4'd1;
    dur_move = 4'd1;
    push(K_GM, g + 3);
    push(K_FM, g + 7);
    push(K_DM, g + 7);
    step(1);
    cancel   = 1'b0;
    req_door = 1'b0;
    req_move = 1'b0;
    step(6);

    // Cancel coincident with the final tick: no done pulse
    req_move = 1'b1;
    dur_move = 4'd1;
    g = cyc + 1;
    push(K_GM, g);
    push(K_FM, g + 4);
    step(1);
    req_move = 1'b0;
    step(3);
    cancel = 1'b1;
    step(1);
    cancel = 1'b0;
    step(3);

    // Reset mid-interval clears outputs immediately; fresh full interval after
    req_door = 1'b1;
    dur_door = 4'd2;
    g = cyc + 1;
    push(K_GD, g);
    push(K_FD, g + 3);
    step(4);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({grant_door, grant_move, busy, done_door, done_move, tick_out}), 32'd0);
    step(2);
    rst_n = 1'b1;
    r = cyc;
    push(K_GD, r + 1);
    push(K_FD, r + 9);
    push(K_DD, r + 9);
    step(1);
    req_door = 1'b0;
    step(10);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_events: got %0d unobserved, expected 0 (next %s@%0d)",
               exp_q.size(), kname(exp_q[0].kind), exp_q[0].cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
